// File: rtl/wb_whitebox_mon.sv
// Passive Wishbone observer: beat statistics, latency tracking,
// sticky timeout/protocol flags and last-beat capture.
module wb_whitebox_mon #(
    parameter int  AW        = 32,
    parameter int  DW        = 32,
    parameter int  CNT_W     = 16,
    parameter int  TO_CYCLES = 256,
    localparam int SW        = DW / 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic             wb_ack_o,
    input  logic [AW-1:0]    wb_addr_i,
    input  logic [DW-1:0]    wb_dat_i,
    input  logic [DW-1:0]    wb_dat_o,
    input  logic [SW-1:0]    wb_sel_i,
    input  logic [2:0]       wb_cti_i,
    input  logic             mon_en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic [CNT_W-1:0] burst_cnt_o,
    output logic [CNT_W-1:0] max_lat_o,
    output logic             err_timeout_o,
    output logic             err_proto_o,
    output logic [AW-1:0]    last_addr_o,
    output logic [DW-1:0]    last_data_o,
    output logic [SW-1:0]    last_sel_o,
    output logic             last_we_o,
    output logic             last_valid_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TO_CYCLES);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] lat_acc;
    logic [CNT_W-1:0] cur_lat;
    logic [AW-1:0]    req_addr;
    logic [SW-1:0]    req_sel;
    logic             req_we;
    logic             req;
    logic             beat;
    logic             cti_inc;
    logic             cti_end;
    logic             changed;
    logic             proto_hit;
    logic             burst_done;
    logic             timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign req     = wb_cyc_i & wb_stb_i;
    assign beat    = req & wb_ack_o;
    assign cti_inc = (wb_cti_i == 3'b010);
    assign cti_end = (wb_cti_i == 3'b111);
    assign changed = (wb_addr_i != req_addr) | (wb_we_i != req_we)
                   | (wb_sel_i != req_sel);
    // Latency of the current cycle, counting it; saturates
    assign cur_lat     = (&lat_acc) ? lat_acc : lat_acc + CNT_W'(1);
    assign timeout_hit = req & ~wb_ack_o & (cur_lat >= TO_CNT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (!mon_en_i) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (beat && cti_inc)       state_n = S_BURST;
                    else if (req && !wb_ack_o) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (beat)      state_n = cti_inc ? S_BURST : S_IDLE;
                    else if (!req) state_n = S_IDLE;
                end
                S_BURST: begin
                    if (beat && cti_end) state_n = S_IDLE;
                    else if (!wb_cyc_i)  state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        proto_hit  = wb_ack_o & ~req;
        burst_done = 1'b0;
        unique case (state)
            S_WAIT: begin
                if (!req)                      proto_hit = 1'b1;
                else if (!wb_ack_o && changed) proto_hit = 1'b1;
            end
            S_BURST: begin
                if (beat && cti_end) burst_done = 1'b1;
                else if (!wb_cyc_i)  proto_hit  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            lat_acc      <= '0;
            req_addr     <= '0;
            req_sel      <= '0;
            req_we       <= 1'b0;
            last_addr_o  <= '0;
            last_data_o  <= '0;
            last_sel_o   <= '0;
            last_we_o    <= 1'b0;
            last_valid_o <= 1'b0;
        end else begin
            if (req) begin
                req_addr <= wb_addr_i;
                req_sel  <= wb_sel_i;
                req_we   <= wb_we_i;
            end
            lat_acc      <= (mon_en_i && req && !wb_ack_o) ? cur_lat : '0;
            last_valid_o <= mon_en_i & beat;
            if (mon_en_i && beat) begin
                last_addr_o <= wb_addr_i;
                last_data_o <= wb_we_i ? wb_dat_i : wb_dat_o;
                last_sel_o  <= wb_sel_i;
                last_we_o   <= wb_we_i;
            end
        end
    end

    // Clear wins over any event in the same cycle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr_i) begin
            rd_cnt_o      <= '0;
            wr_cnt_o      <= '0;
            burst_cnt_o   <= '0;
            max_lat_o     <= '0;
            err_timeout_o <= 1'b0;
            err_proto_o   <= 1'b0;
        end else if (mon_en_i) begin
            if (beat && wb_we_i)  wr_cnt_o    <= sat_inc(wr_cnt_o);
            if (beat && !wb_we_i) rd_cnt_o    <= sat_inc(rd_cnt_o);
            if (burst_done)       burst_cnt_o <= sat_inc(burst_cnt_o);
            if (beat && cur_lat > max_lat_o) max_lat_o <= cur_lat;
            if (timeout_hit) err_timeout_o <= 1'b1;
            if (proto_hit)   err_proto_o   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_whitebox_mon.sv
// Randomized bench for wb_whitebox_mon: two instances against a
// cycle-level reference model plus directed literal checks.
module tb_wb_whitebox_mon;

    localparam int CW0 = 16;
    localparam int TO0 = 8;
    localparam int CW1 = 4;
    localparam int TO1 = 5;
    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_BURST = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cyc, stb, we, ack, en, clr;
    logic [31:0] addr, dati, dato;
    logic [3:0]  sel;
    logic [2:0]  cti;

    logic [15:0] rd0, wr0, bu0, mx0;
    logic [3:0]  rd1, wr1, bu1, mx1;
    logic        eto0, epr0, lw0, lv0, eto1, epr1, lw1, lv1;
    logic [31:0] la0, ld0, la1, ld1;
    logic [3:0]  ls0, ls1;

    int n_cmp = 0;
    int n_bad = 0;

    wb_whitebox_mon #(.AW(32), .DW(32), .CNT_W(CW0), .TO_CYCLES(TO0)) u0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_ack_o(ack), .wb_addr_i(addr), .wb_dat_i(dati),
        .wb_dat_o(dato), .wb_sel_i(sel), .wb_cti_i(cti), .mon_en_i(en),
        .clr_i(clr), .rd_cnt_o(rd0), .wr_cnt_o(wr0), .burst_cnt_o(bu0),
        .max_lat_o(mx0), .err_timeout_o(eto0), .err_proto_o(epr0),
        .last_addr_o(la0), .last_data_o(ld0), .last_sel_o(ls0),
        .last_we_o(lw0), .last_valid_o(lv0)
    );

    wb_whitebox_mon #(.AW(32), .DW(32), .CNT_W(CW1), .TO_CYCLES(TO1)) u1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_ack_o(ack), .wb_addr_i(addr), .wb_dat_i(dati),
        .wb_dat_o(dato), .wb_sel_i(sel), .wb_cti_i(cti), .mon_en_i(en),
        .clr_i(clr), .rd_cnt_o(rd1), .wr_cnt_o(wr1), .burst_cnt_o(bu1),
        .max_lat_o(mx1), .err_timeout_o(eto1), .err_proto_o(epr1),
        .last_addr_o(la1), .last_data_o(ld1), .last_sel_o(ls1),
        .last_we_o(lw1), .last_valid_o(lv1)
    );

    typedef struct {
        int          rd, wr, bu, mx, lat, ph;
        bit          eto, epr, lw, lv, pw;
        logic [31:0] la, ld, pa;
        logic [3:0]  ls, ps;
    } mdl_t;

    mdl_t m[2];

    function automatic mdl_t mz();
        mdl_t z;
        z.rd = 0; z.wr = 0; z.bu = 0; z.mx = 0; z.lat = 0; z.ph = P_IDLE;
        z.eto = 0; z.epr = 0; z.lw = 0; z.lv = 0; z.pw = 0;
        z.la = '0; z.ld = '0; z.pa = '0; z.ls = '0; z.ps = '0;
        return z;
    endfunction

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // One bus cycle of the monitor's documented behaviour
    task automatic step(int i);
        mdl_t s, n;
        int   cap, tov, cur;
        bit   rq, bt, proto, tmo, bdone;
        cap = (i == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
        tov = (i == 0) ? TO0 : TO1;
        if (rst) begin
            m[i] = mz();
            return;
        end
        s = m[i];
        n = s;
        rq = cyc && stb;
        bt = rq && ack;
        cur = min2(s.lat + 1, cap);
        proto = ack && !rq;
        bdone = 0;
        tmo = rq && !ack && (cur >= tov);
        if (!en) n.ph = P_IDLE;
        else if (s.ph == P_IDLE) begin
            if (bt && cti == 3'b010) n.ph = P_BURST;
            else if (rq && !ack)     n.ph = P_WAIT;
        end else if (s.ph == P_WAIT) begin
            if (bt) n.ph = (cti == 3'b010) ? P_BURST : P_IDLE;
            else if (!rq) begin n.ph = P_IDLE; proto = 1; end
            else if (addr !== s.pa || we !== s.pw || sel !== s.ps) proto = 1;
        end else begin
            if (bt && cti == 3'b111) begin n.ph = P_IDLE; bdone = 1; end
            else if (!cyc) begin n.ph = P_IDLE; proto = 1; end
        end
        n.lv = en && bt;
        if (en && bt) begin
            n.la = addr; n.ls = sel; n.lw = we;
            n.ld = we ? dati : dato;
        end
        if (clr) begin
            n.rd = 0; n.wr = 0; n.bu = 0; n.mx = 0; n.eto = 0; n.epr = 0;
        end else if (en) begin
            if (bt && we)  n.wr = min2(s.wr + 1, cap);
            if (bt && !we) n.rd = min2(s.rd + 1, cap);
            if (bdone)     n.bu = min2(s.bu + 1, cap);
            if (bt && cur > s.mx) n.mx = cur;
            if (tmo)   n.eto = 1;
            if (proto) n.epr = 1;
        end
        if (rq) begin n.pa = addr; n.pw = we; n.ps = sel; end
        n.lat = (en && rq && !ack) ? cur : 0;
        m[i] = n;
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cmpi(int i, input logic [15:0] rd, wr, bu, mx,
                        input logic eto, epr, input logic [31:0] la, ld,
                        input logic [3:0] ls, input logic lw, lv);
        string p;
        p = (i == 0) ? "u0" : "u1";
        chk({p, ".rd_cnt"},   64'(rd),  64'(m[i].rd));
        chk({p, ".wr_cnt"},   64'(wr),  64'(m[i].wr));
        chk({p, ".burst_cnt"}, 64'(bu), 64'(m[i].bu));
        chk({p, ".max_lat"},  64'(mx),  64'(m[i].mx));
        chk({p, ".err_to"},   64'(eto), 64'(m[i].eto));
        chk({p, ".err_pr"},   64'(epr), 64'(m[i].epr));
        chk({p, ".last_addr"}, 64'(la), 64'(m[i].la));
        chk({p, ".last_data"}, 64'(ld), 64'(m[i].ld));
        chk({p, ".last_sel"}, 64'(ls),  64'(m[i].ls));
        chk({p, ".last_we"},  64'(lw),  64'(m[i].lw));
        chk({p, ".last_vld"}, 64'(lv),  64'(m[i].lv));
    endtask

    always @(posedge clk) begin
        step(0);
        step(1);
    end

    always @(posedge clk) begin
        #1;
        cmpi(0, rd0, wr0, bu0, mx0, eto0, epr0, la0, ld0, ls0, lw0, lv0);
        cmpi(1, {12'd0, rd1}, {12'd0, wr1}, {12'd0, bu1}, {12'd0, mx1},
             eto1, epr1, la1, ld1, ls1, lw1, lv1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(int n);
        cyc = 0; stb = 0; ack = 0; clr = 0; cti = 3'b000;
        repeat (n) begin
            dati = $urandom; dato = $urandom;
            tick();
        end
    endtask

    task automatic clear();
        cyc = 0; stb = 0; ack = 0; clr = 1;
        tick();
        clr = 0;
    endtask

    task automatic beat(bit w, logic [31:0] a, logic [31:0] d, logic [2:0] ct);
        cyc = 1; stb = 1; ack = 1; we = w; addr = a; cti = ct; sel = 4'hF;
        if (w) begin dati = d; dato = $urandom; end
        else begin dato = d; dati = $urandom; end
        tick();
    endtask

    task automatic hold(int n);
        ack = 0;
        repeat (n) begin
            dato = $urandom;
            tick();
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, " rd0"}, 64'(rd0), 0);
        chk({tag, " wr0"}, 64'(wr0), 0);
        chk({tag, " bu0"}, 64'(bu0), 0);
        chk({tag, " mx0"}, 64'(mx0), 0);
        chk({tag, " err0"}, 64'({eto0, epr0}), 0);
        chk({tag, " last0"}, 64'({la0, lv0, lw0, ls0}), 0);
        chk({tag, " ld0"}, 64'(ld0), 0);
        chk({tag, " cnt1"}, 64'({rd1, wr1, bu1, mx1}), 0);
        chk({tag, " misc1"}, 64'({eto1, epr1, lv1, lw1, ls1}), 0);
    endtask

    task automatic rnd_single();
        int nw, viol;
        nw = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 20)
                                         : $urandom_range(0, 3);
        viol = $urandom_range(0, 9);
        cyc = 1; stb = 1; we = 1'($urandom_range(0, 1));
        addr = $urandom; sel = 4'($urandom);
        cti = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'b000;
        for (int k = 0; k < nw; k++) begin
            ack = 0; dati = $urandom; dato = $urandom;
            if (viol == 0 && k > 0) addr = addr ^ 32'h4;
            tick();
        end
        if (viol == 1 && nw > 0) begin
            stb = 0;
            tick();
            idle(1);
            return;
        end
        ack = 1; dati = $urandom; dato = $urandom;
        clr = ($urandom_range(0, 9) == 0);
        tick();
        clr = 0; ack = 0;
        if ($urandom_range(0, 1) == 1) idle(1);
    endtask

    task automatic rnd_burst();
        int nb, drop;
        nb = $urandom_range(2, 6);
        drop = ($urandom_range(0, 5) == 0) ? $urandom_range(1, nb - 1) : 0;
        cyc = 1; stb = 1; we = 1'($urandom_range(0, 1));
        sel = 4'($urandom); addr = $urandom;
        for (int b = 0; b < nb; b++) begin
            if (drop != 0 && b == drop) begin
                cyc = 0; stb = 0; ack = 0;
                tick();
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                ack = 0; cti = 3'b010; dati = $urandom; dato = $urandom;
                tick();
            end
            ack = 1; cti = (b == nb - 1) ? 3'b111 : 3'b010;
            dati = $urandom; dato = $urandom;
            tick();
            addr = addr + 32'd4;
        end
        idle(1);
    endtask

    initial begin
        rst = 1; cyc = 0; stb = 0; we = 0; ack = 0; en = 1; clr = 0;
        addr = 0; dati = 0; dato = 0; sel = 0; cti = 0;
        tick(); tick();
        chk_zero("reset");
        rst = 0;
        idle(1);

        beat(1, 32'h100, 32'hDEADBEEF, 3'b000);
        chk("wr_one", 64'(wr0), 1);
        chk("data_wr", 64'(ld0), 64'hDEADBEEF);
        chk("valid_hi", 64'(lv0), 1);
        chk("lat_one", 64'(mx0), 1);
        chk("addr_wr", 64'(la0), 64'h100);
        idle(1);
        chk("valid_lo", 64'(lv0), 0);

        clear();
        cyc = 1; stb = 1; we = 0; addr = 32'h200; sel = 4'hF; cti = 0;
        hold(3);
        beat(0, 32'h200, 32'h12345678, 3'b000);
        chk("rd_one", 64'(rd0), 1);
        chk("lat_four", 64'(mx0), 4);
        chk("we_rd", 64'(lw0), 0);
        chk("data_rd", 64'(ld0), 64'h12345678);
        idle(1);

        clear();
        beat(0, 32'h10, 32'h1, 3'b010);
        beat(0, 32'h14, 32'h2, 3'b010);
        beat(0, 32'h18, 32'h3, 3'b010);
        beat(0, 32'h1C, 32'h4, 3'b111);
        chk("burst_cnt", 64'(bu0), 1);
        chk("burst_rd", 64'(rd0), 4);
        chk("burst_ok", 64'(epr0), 0);
        idle(1);

        clear();
        beat(0, 32'h20, 32'h1, 3'b010);
        beat(0, 32'h24, 32'h2, 3'b010);
        idle(1);
        chk("drop_err", 64'(epr0), 1);
        chk("drop_bu", 64'(bu0), 0);
        chk("drop_rd", 64'(rd0), 2);

        clear();
        cyc = 1; stb = 1; we = 0; addr = 32'h300; sel = 4'h3; cti = 0;
        hold(5);
        chk("to_u1", 64'(eto1), 1);
        hold(2);
        chk("to_early", 64'(eto0), 0);
        hold(1);
        chk("to_set", 64'(eto0), 1);
        idle(1);
        clear();
        chk("clr_to", 64'(eto0), 0);
        chk("clr_pr", 64'(epr0), 0);
        chk("clr_mx", 64'(mx0), 0);

        cyc = 0; stb = 0; ack = 1;
        tick();
        chk("stray_ack", 64'(epr0), 1);
        clear();

        clr = 1;
        beat(1, 32'h400, 32'hCAFE, 3'b000);
        clr = 0;
        chk("clr_beat_wr", 64'(wr0), 0);
        chk("clr_beat_la", 64'(la0), 64'h400);
        chk("clr_beat_lv", 64'(lv0), 1);
        idle(1);

        en = 0;
        beat(1, 32'h500, 32'hBEEF, 3'b000);
        chk("dis_wr", 64'(wr0), 0);
        chk("dis_lv", 64'(lv0), 0);
        chk("dis_la", 64'(la0), 64'h400);
        idle(1);
        en = 1;
        idle(1);

        clear();
        for (int k = 0; k < 20; k++) beat(1, 32'(k * 4), 32'(k), 3'b000);
        chk("sat_wr1", 64'(wr1), 15);
        chk("sat_wr0", 64'(wr0), 20);
        idle(1);

        beat(0, 32'h600, 32'h9, 3'b010);
        beat(0, 32'h604, 32'hA, 3'b010);
        rst = 1; ack = 0;
        tick();
        chk_zero("midrst");
        rst = 0;
        beat(0, 32'h608, 32'h55, 3'b111);
        chk("rst_bu", 64'(bu0), 0);
        chk("rst_rd", 64'(rd0), 1);
        idle(2);

        for (int t = 0; t < 400; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rnd_single();
                4, 5: rnd_burst();
                6: begin
                    idle($urandom_range(1, 3));
                    clr = 1;
                    tick();
                    clr = 0;
                end
                7: begin
                    cyc = 1'($urandom_range(0, 1)); stb = 0; ack = 1;
                    tick();
                    idle(1);
                end
                8: begin
                    idle(1);
                    en = ~en;
                    idle($urandom_range(1, 2));
                end
                default: begin
                    idle(1);
                    if ($urandom_range(0, 3) == 0) begin
                        rst = 1;
                        tick();
                        rst = 0;
                    end
                end
            endcase
        end
        en = 1;
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_whitebox_mon.md
WB_WHITEBOX_MON -- requirements
Module: wb_whitebox_mon

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width; SW = DW/8 select width, derived.
REQ-003 SHALL have parameter CNT_W, default 16, width of every counter output.
REQ-004 SHALL have parameter TO_CYCLES, default 256, ack-timeout threshold in cycles (1..2^CNT_W-1).
REQ-005 SHALL have port wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port wb_rst_i  in  1  reset, synchronous and active-high.
REQ-007 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o  in  1 each  observed Wishbone handshake.
REQ-008 SHALL have ports wb_addr_i [AW], wb_dat_i [DW], wb_dat_o [DW], wb_sel_i [SW], wb_cti_i [3]  in  observed bus fields.
REQ-009 SHALL have ports mon_en_i  in  1  monitor enable; clr_i  in  1  clear counters and sticky flags.
REQ-010 SHALL have outputs rd_cnt_o, wr_cnt_o, burst_cnt_o, max_lat_o  out  CNT_W  statistics.
REQ-011 SHALL have outputs err_timeout_o, err_proto_o  out  1  sticky error flags.
REQ-012 SHALL have outputs last_addr_o [AW], last_data_o [DW], last_sel_o [SW], last_we_o [1], last_valid_o [1]  out  last-beat capture.

Function
REQ-013 SHALL be purely observational: no output drives the bus.
REQ-014 SHALL define a beat as a cycle with wb_cyc_i & wb_stb_i & wb_ack_o all high.
REQ-015 SHALL implement FSM states IDLE, WAIT, BURST; reset state IDLE.
REQ-016 IDLE: cyc&stb&!ack -> WAIT; beat with cti=3'b010 -> BURST; otherwise stay IDLE.
REQ-017 WAIT: beat with cti=3'b010 -> BURST; other beat -> IDLE; stb or cyc dropped without ack -> IDLE and set err_proto_o.
REQ-018 BURST: beat with cti=3'b111 -> IDLE and burst_cnt_o +1; cyc dropped before that beat -> IDLE and set err_proto_o; else stay.
REQ-019 SHALL increment wr_cnt_o on a write beat (we=1), rd_cnt_o on a read beat, one cycle after the beat.
REQ-020 SHALL, one cycle after each beat, register last_addr_o=addr, last_sel_o=sel, last_we_o=we, last_data_o = wb_dat_i if write else wb_dat_o, and pulse last_valid_o high for exactly one cycle.
REQ-021 SHALL count beat latency as cycles with cyc&stb high since the previous beat or strobe start, inclusive of the ack cycle (single-cycle ack = 1); max_lat_o SHALL hold the maximum seen.
REQ-022 SHALL set err_timeout_o when latency count reaches TO_CYCLES without ack; FSM remains in WAIT; latency counter saturates.
REQ-023 SHALL set err_proto_o when wb_ack_o is high while cyc&stb is not, or when addr, we or sel changes while in WAIT with no ack.
REQ-024 All counters SHALL saturate at all-ones, never wrap.
REQ-025 Sticky flags SHALL remain set until clr_i or reset.
REQ-026 clr_i SHALL zero all counters, max_lat_o and both error flags next cycle; a beat coincident with clr_i SHALL NOT be counted but SHALL still update last_* capture; FSM state unaffected.
REQ-027 mon_en_i low SHALL force FSM to IDLE, freeze counters and flags, and suppress last_valid_o; capture registers hold.
REQ-028 Beat in same cycle as an error condition SHALL both count and set the flag.

Reset
REQ-029 wb_rst_i high SHALL, at the next clock edge, force FSM to IDLE and every output to zero, overriding clr_i and mon_en_i, including mid-burst or mid-wait.

Verification
REQ-030 Write beat addr=0x100, dat_i=0xDEADBEEF, sel=4'hF, ack on first cycle -> next cycle wr_cnt_o=1, last_data_o=0xDEADBEEF, last_valid_o 1 cycle, max_lat_o=1.
REQ-031 Read, ack after 3 wait cycles, dat_o=0x12345678 -> rd_cnt_o=1, max_lat_o=4, last_we_o=0.
REQ-032 4-beat burst cti 010,010,010,111 -> burst_cnt_o=1, rd_cnt_o=4, FSM back to IDLE; same burst with cyc dropped after beat 2 -> err_proto_o=1, burst_cnt_o=0.
REQ-033 TO_CYCLES=8, stb held 8 cycles no ack -> err_timeout_o=1 on cycle 8; clr_i pulse -> all counters and flags 0.
REQ-034 CNT_W=4, 20 write beats -> wr_cnt_o=15 (saturated); wb_rst_i mid-burst -> all outputs 0, FSM IDLE.
